// File: rtl/fwd_pkg.sv
// Shared select codes and tag control layout for the forwarding/hazard unit.
// SEL_X is only produced when FWD_WB_HOLD_EN is defined.
package fwd_pkg;

  localparam int unsigned SEL_WIDTH = 2;

  typedef enum logic [SEL_WIDTH-1:0] {
    SEL_NORM = 2'b00,
    SEL_W    = 2'b01,
    SEL_M    = 2'b10,
    SEL_X    = 2'b11
  } fwd_sel_e;

  // Control part of one in-flight tag; the destination address travels
  // alongside it because its width follows REG_AW.
  typedef struct packed {
    logic rw;
    logic mr;
  } tag_ctl_t;

  localparam tag_ctl_t TAG_BUBBLE = '{rw: 1'b0, mr: 1'b0};

endpackage

// File: rtl/fwd_cmp.sv
// Compares one D-stage source against the in-flight E/M(/W) tags and returns
// the select to register into E. W tag ports exist only with FWD_WB_HOLD_EN.
module fwd_cmp
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  logic [REG_AW-1:0] e_dst,
  input  tag_ctl_t          e_ctl,
  input  logic [REG_AW-1:0] m_dst,
  input  logic              m_rw,
`ifdef FWD_WB_HOLD_EN
  input  logic [REG_AW-1:0] w_dst,
  input  logic              w_rw,
`endif
  output fwd_sel_e          sel
);

  always_comb begin
    sel = SEL_NORM;
    if (src != '0) begin
      // A load in E cannot forward; the stall logic handles that case.
      if (used && e_ctl.rw && !e_ctl.mr && (e_dst == src)) begin
        sel = SEL_M;
      end else if (m_rw && (m_dst == src)) begin
        sel = SEL_W;
      end
`ifdef FWD_WB_HOLD_EN
      else if (w_rw && (w_dst == src)) begin
        sel = SEL_X;
      end
`endif
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// E-stage operand forwarding with D-stage select precompute and load-use stall.
// Define FWD_WB_HOLD_EN to add the X (W+1) hold stage and SEL_X path.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pipe_en,
  input  logic                        flush_e,
  input  logic [NUM_SRC*REG_AW-1:0]   d_src_addr,
  input  logic [NUM_SRC-1:0]          d_src_used,
  input  logic [REG_AW-1:0]           d_dst_addr,
  input  logic                        d_reg_write,
  input  logic                        d_mem_read,
  input  logic [NUM_SRC*DATA_W-1:0]   e_src_data,
  input  logic [DATA_W-1:0]           alu_out_m,
  input  logic [DATA_W-1:0]           result_w,
  output logic [NUM_SRC*DATA_W-1:0]   e_opnd,
  output logic [NUM_SRC*SEL_WIDTH-1:0] e_fwd_sel,
  output logic                        load_use_stall
);

  logic [REG_AW-1:0]         e_dst;
  tag_ctl_t                  e_ctl;
  logic [NUM_SRC*REG_AW-1:0] e_src_addr;
  logic [NUM_SRC-1:0]        e_src_used;
  logic [REG_AW-1:0]         m_dst;
  tag_ctl_t                  m_ctl;
  logic [REG_AW-1:0]         w_dst;
  logic                      w_rw;
`ifdef FWD_WB_HOLD_EN
  logic [REG_AW-1:0]         x_dst;
  logic                      x_rw;
  logic [DATA_W-1:0]         x_data;
`endif

  fwd_sel_e sel_d [NUM_SRC];
  fwd_sel_e sel_q [NUM_SRC];
  logic     use_hit;
  logic     unused_tags;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cmp
    fwd_cmp #(.REG_AW(REG_AW)) u_cmp (
      .src   (d_src_addr[g*REG_AW +: REG_AW]),
      .used  (d_src_used[g]),
      .e_dst (e_dst),
      .e_ctl (e_ctl),
      .m_dst (m_dst),
      .m_rw  (m_ctl.rw),
`ifdef FWD_WB_HOLD_EN
      .w_dst (w_dst),
      .w_rw  (w_rw),
`endif
      .sel   (sel_d[g])
    );
  end

  always_comb begin
    use_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (d_src_used[i] && (d_src_addr[i*REG_AW +: REG_AW] == e_dst)) use_hit = 1'b1;
    end
    load_use_stall = e_ctl.mr && e_ctl.rw && (e_dst != '0) && use_hit;
  end

  always_comb begin
    e_opnd    = '0;
    e_fwd_sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      e_fwd_sel[i*SEL_WIDTH +: SEL_WIDTH] = sel_q[i];
      case (sel_q[i])
        SEL_W:   e_opnd[i*DATA_W +: DATA_W] = result_w;
        SEL_M:   e_opnd[i*DATA_W +: DATA_W] = alu_out_m;
`ifdef FWD_WB_HOLD_EN
        SEL_X:   e_opnd[i*DATA_W +: DATA_W] = x_data;
`endif
        default: e_opnd[i*DATA_W +: DATA_W] = e_src_data[i*DATA_W +: DATA_W];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_dst      <= '0;
      e_ctl      <= TAG_BUBBLE;
      e_src_addr <= '0;
      e_src_used <= '0;
      m_dst      <= '0;
      m_ctl      <= TAG_BUBBLE;
      w_dst      <= '0;
      w_rw       <= 1'b0;
`ifdef FWD_WB_HOLD_EN
      x_dst      <= '0;
      x_rw       <= 1'b0;
      x_data     <= '0;
`endif
      for (int unsigned i = 0; i < NUM_SRC; i++) sel_q[i] <= SEL_NORM;
    end else if (pipe_en) begin
      e_dst      <= d_dst_addr;
      e_src_addr <= d_src_addr;
      // Flush and stall collapse into the same single bubble.
      if (flush_e || load_use_stall) begin
        e_ctl      <= TAG_BUBBLE;
        e_src_used <= '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) sel_q[i] <= SEL_NORM;
      end else begin
        e_ctl      <= '{rw: d_reg_write, mr: d_mem_read};
        e_src_used <= d_src_used;
        for (int unsigned i = 0; i < NUM_SRC; i++) sel_q[i] <= sel_d[i];
      end
      m_dst <= e_dst;
      m_ctl <= e_ctl;
      w_dst <= m_dst;
      w_rw  <= m_ctl.rw;
`ifdef FWD_WB_HOLD_EN
      x_dst  <= w_dst;
      x_rw   <= w_rw;
      x_data <= result_w;
`endif
    end
  end

`ifdef FWD_WB_HOLD_EN
  assign unused_tags = ^{e_src_addr, e_src_used, m_ctl.mr, x_dst, x_rw};
`else
  assign unused_tags = ^{e_src_addr, e_src_used, m_ctl.mr, w_dst, w_rw};
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, hand sequences
// for reset and the X stage (FWD_WB_HOLD_EN), then random traffic vs. a model.
module tb_fwd_hazard_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           pipe_en;
  logic           flush_e;
  logic [NS*AW-1:0] d_src_addr;
  logic [NS-1:0]  d_src_used;
  logic [AW-1:0]  d_dst_addr;
  logic           d_reg_write;
  logic           d_mem_read;
  logic [NS*DW-1:0] e_src_data;
  logic [DW-1:0]  alu_out_m;
  logic [DW-1:0]  result_w;
  logic [NS*DW-1:0] e_opnd;
  logic [NS*2-1:0] e_fwd_sel;
  logic           load_use_stall;

  fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_en        (pipe_en),
    .flush_e        (flush_e),
    .d_src_addr     (d_src_addr),
    .d_src_used     (d_src_used),
    .d_dst_addr     (d_dst_addr),
    .d_reg_write    (d_reg_write),
    .d_mem_read     (d_mem_read),
    .e_src_data     (e_src_data),
    .alu_out_m      (alu_out_m),
    .result_w       (result_w),
    .e_opnd         (e_opnd),
    .e_fwd_sel      (e_fwd_sel),
    .load_use_stall (load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pe, fl;
    logic [4:0] s0, s1;
    logic [1:0] used;
    logic [4:0] dst;
    logic       rw, mr;
    logic       exp_stall;
    logic [1:0] e0, e1;
  } vec_t;

  typedef struct packed {
    logic [4:0] dst;
    logic       rw;
    logic       mr;
  } mtag_t;

  int errors = 0;
  int checks = 0;
  vec_t tbl [17];

  // Reference state: ms[0]=E, 1=M, 2=W, 3=X (distance from D minus one).
  mtag_t      ms [4];
  logic [1:0] m_sel [NS];
`ifdef FWD_WB_HOLD_EN
  logic [DW-1:0] m_x;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int pe, int fl, int s0, int s1, int used, int dst,
                              int rw, int mr, int st, int e0, int e1);
    vec_t v;
    v.pe = 1'(pe); v.fl = 1'(fl); v.s0 = 5'(s0); v.s1 = 5'(s1);
    v.used = 2'(used); v.dst = 5'(dst); v.rw = 1'(rw); v.mr = 1'(mr);
    v.exp_stall = 1'(st); v.e0 = 2'(e0); v.e1 = 2'(e1);
    return v;
  endfunction

  task automatic drive(input logic pe_i, input logic fl_i, input logic [4:0] s0,
                       input logic [4:0] s1, input logic [1:0] u, input logic [4:0] dst,
                       input logic rw_i, input logic mr_i);
    pipe_en = pe_i; flush_e = fl_i;
    d_src_addr = {s1, s0}; d_src_used = u;
    d_dst_addr = dst; d_reg_write = rw_i; d_mem_read = mr_i;
  endtask

  function automatic logic [31:0] exp_op(input int i, input logic [1:0] s);
    case (s)
      2'b01: return result_w;
      2'b10: return alu_out_m;
`ifdef FWD_WB_HOLD_EN
      2'b11: return m_x;
`endif
      default: return e_src_data[i*32 +: 32];
    endcase
  endfunction

  // Nearest producer whose value is available wins; r0 is never forwarded.
  function automatic logic [1:0] pick(input logic [4:0] src, input logic used);
    if (src == 5'd0) return 2'b00;
    if (used && ms[0].rw && !ms[0].mr && ms[0].dst == src) return 2'b10;
    if (ms[1].rw && ms[1].dst == src) return 2'b01;
`ifdef FWD_WB_HOLD_EN
    if (ms[2].rw && ms[2].dst == src) return 2'b11;
`endif
    return 2'b00;
  endfunction

  task automatic check_sel_op(input string tag, input logic [1:0] e0, input logic [1:0] e1);
    chk({tag, "_sel0"}, e_fwd_sel[1:0], e0);
    chk({tag, "_sel1"}, e_fwd_sel[3:2], e1);
    chk({tag, "_op0"}, e_opnd[31:0], exp_op(0, e0));
    chk({tag, "_op1"}, e_opnd[63:32], exp_op(1, e1));
  endtask

  initial begin
    logic [1:0] nsel [NS];
    logic       st;
    logic [DW-1:0] xcap;
    logic [4:0] rs0, rs1, rdst;
    logic [1:0] ru;
    logic       rpe, rfl, rrw, rmr;

    //            pe fl s0 s1 u  dst rw mr st e0 e1
    tbl[0]  = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);   // add r3
    tbl[1]  = mk(1, 0, 3, 0, 1, 7, 1, 0, 0, 2, 0);   // back-to-back r3 -> M
    tbl[2]  = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);   // producer r4
    tbl[3]  = mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);   // independent
    tbl[4]  = mk(1, 0, 0, 4, 2, 9, 0, 0, 0, 0, 1);   // distance-2 r4 -> W
    tbl[5]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 5, 0, 1, 0, 1, 0, 0, 2, 0);   // double hit r5 -> M; writes r0
    tbl[8]  = mk(1, 0, 0, 0, 3, 10, 0, 0, 0, 0, 0);  // reads r0 -> NORM
    tbl[9]  = mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);   // lw r6
    tbl[10] = mk(1, 0, 6, 0, 1, 11, 1, 0, 1, 0, 0);  // load-use stall
    tbl[11] = mk(1, 0, 6, 0, 1, 11, 1, 0, 0, 1, 0);  // replay -> W
    tbl[12] = mk(0, 1, 0, 11, 2, 0, 0, 0, 0, 1, 0);  // frozen
    tbl[13] = mk(0, 1, 0, 11, 2, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(0, 1, 0, 11, 2, 0, 0, 0, 0, 1, 0);
    tbl[15] = mk(1, 1, 0, 11, 2, 0, 0, 0, 0, 0, 0);  // flush on re-enable
    tbl[16] = mk(1, 0, 11, 0, 1, 0, 0, 0, 0, 1, 0);  // M now holds r11

    rst_n = 1'b1;
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    e_src_data = {32'hBBBB0001, 32'hAAAA0000};
    alu_out_m  = 32'h00000055;
    result_w   = 32'h12345678;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_stall", {63'd0, load_use_stall}, 64'd0);
    check_sel_op("rst", 2'b00, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      drive(tbl[k].pe, tbl[k].fl, tbl[k].s0, tbl[k].s1, tbl[k].used,
            tbl[k].dst, tbl[k].rw, tbl[k].mr);
      #8;
      chk($sformatf("t%0d_stall", k), {63'd0, load_use_stall}, {63'd0, tbl[k].exp_stall});
      @(posedge clk); #1;
      check_sel_op($sformatf("t%0d", k), tbl[k].e0, tbl[k].e1);
    end

`ifdef FWD_WB_HOLD_EN
    // Distance-3 producer r12 reaches the consumer through the X hold register.
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 5'd12, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
    result_w = 32'hCAFEF00D;
    @(posedge clk); #1;
    result_w = 32'h0BADBEEF;
    chk("x_sel0", e_fwd_sel[1:0], 2'b11);
    chk("x_op0", e_opnd[31:0], 32'hCAFEF00D);
`endif

    // Mid-stream reset with a live stall and a non-zero select.
    drive(1'b1, 1'b0, 5'd11, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 5'd6, 5'd0, 2'b01, 5'd2, 1'b1, 1'b0);
    #3;
    chk("pre_rst_stall", {63'd0, load_use_stall}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {63'd0, load_use_stall}, 64'd0);
    chk("mid_rst_sel", e_fwd_sel, 4'd0);
    chk("mid_rst_op", e_opnd, e_src_data);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int j = 0; j < 4; j++) ms[j] = '0;
    for (int i = 0; i < NS; i++) m_sel[i] = 2'b00;
`ifdef FWD_WB_HOLD_EN
    m_x = '0;
`endif

    for (int c = 0; c < 400; c++) begin
      rpe  = ($urandom_range(0, 7) != 0);
      rfl  = ($urandom_range(0, 9) == 0);
      rs0  = 5'($urandom_range(0, 3));
      rs1  = 5'($urandom_range(0, 3));
      ru   = 2'($urandom_range(0, 3));
      rdst = 5'($urandom_range(0, 3));
      rrw  = 1'($urandom_range(0, 1));
      rmr  = ($urandom_range(0, 2) == 0);
      drive(rpe, rfl, rs0, rs1, ru, rdst, rrw, rmr);
      e_src_data = {$urandom, $urandom};
      alu_out_m  = $urandom;
      result_w   = $urandom;

      st = ms[0].mr && ms[0].rw && (ms[0].dst != 5'd0) &&
           ((ru[0] && rs0 == ms[0].dst) || (ru[1] && rs1 == ms[0].dst));
      #8;
      chk($sformatf("r%0d_stall", c), {63'd0, load_use_stall}, {63'd0, st});
      chk($sformatf("r%0d_op0", c), e_opnd[31:0], exp_op(0, m_sel[0]));
      chk($sformatf("r%0d_op1", c), e_opnd[63:32], exp_op(1, m_sel[1]));
      nsel[0] = pick(rs0, ru[0]);
      nsel[1] = pick(rs1, ru[1]);
      xcap = result_w;
      @(posedge clk);
      if (rpe) begin
`ifdef FWD_WB_HOLD_EN
        m_x = xcap;
`endif
        ms[3] = ms[2];
        ms[2] = ms[1];
        ms[1] = ms[0];
        if (rfl || st) begin
          ms[0] = '{dst: rdst, rw: 1'b0, mr: 1'b0};
          m_sel[0] = 2'b00; m_sel[1] = 2'b00;
        end else begin
          ms[0] = '{dst: rdst, rw: rrw, mr: rmr};
          m_sel[0] = nsel[0]; m_sel[1] = nsel[1];
        end
      end
      #1;
      chk($sformatf("r%0d_sel0", c), e_fwd_sel[1:0], m_sel[0]);
      chk($sformatf("r%0d_sel1", c), e_fwd_sel[3:2], m_sel[1]);
      if (xcap == 32'hFFFF_FFFF) $display("note: rare xcap value");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the per-operand ALU forwarding mux.
- Tracks destination-register tags of in-flight instructions through E/M/W internally and computes forwarding selects one stage early (D), then registers them into E.
- Drives NUM_SRC forwarded E-stage operands and detects load-use hazards (1-cycle stall plus E bubble).
- Sits between the D/E pipeline register, the ALU inputs and the hazard/stall controller.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width
- NUM_SRC, 2, number of source operands forwarded (rs, rt, ...)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_en  in  1  global advance; 0 freezes all internal registers
- flush_e  in  1  replace the instruction entering E with a bubble
- d_src_addr  in  NUM_SRC*REG_AW  D-stage source register addresses, operand i at [i*REG_AW +: REG_AW]
- d_src_used  in  NUM_SRC  D-stage operand i is actually read
- d_dst_addr  in  REG_AW  D-stage destination register
- d_reg_write  in  1  D-stage instruction writes the register file
- d_mem_read  in  1  D-stage instruction is a load
- e_src_data  in  NUM_SRC*DATA_W  register-file operands already in E
- alu_out_m  in  DATA_W  M-stage ALU result
- result_w  in  DATA_W  W-stage write-back value
- e_opnd  out  NUM_SRC*DATA_W  forwarded operands to the ALU
- e_fwd_sel  out  NUM_SRC*2  registered select per operand
- load_use_stall  out  1  stall D/F and bubble E this cycle

Behaviour:
- Tag pipeline of registered fields:
  - E: dst, rw, mr, src_addr[], src_used[]
  - M: dst, rw, mr
  - W: dst, rw
- All tags advance on clk when pipe_en=1 and hold when pipe_en=0.
- Select codes (package): SEL_NORM=00, SEL_W=01, SEL_M=10, SEL_X=11 (optional feature only).
- Next-cycle select for operand i, computed in D:
  - Hit on E tag (will be in M next cycle): src_used[i] & rw_E & !mr_E & dst_E==src[i] & src[i]!=0 -> SEL_M.
  - Else hit on M tag (will be in W next cycle): rw_M & dst_M==src[i] & src[i]!=0 -> SEL_W.
  - Else SEL_NORM. M has priority over W. Register 0 is never forwarded.
- load_use_stall is combinational: mr_E & rw_E & dst_E!=0 & any i (d_src_used[i] & d_src_addr[i]==dst_E). Reset value 0.
- On a clk edge with pipe_en=1:
  - If flush_e or load_use_stall: E tag becomes a bubble (rw=0, mr=0, used=0) and e_fwd_sel<=SEL_NORM for all operands.
  - Otherwise E is loaded from the D inputs and e_fwd_sel from the computed selects.
  - M<=E and W<=M regardless of stall or flush.
- After a load-use stall, the consumer re-evaluates in D. The load is then in M, so the consumer gets SEL_W (load data arrives via result_w).
- flush_e is ignored while pipe_en=0. Flush and stall together produce a single bubble.
- e_opnd[i] is combinational: SEL_NORM -> e_src_data[i], SEL_W -> result_w, SEL_M -> alu_out_m. Undefined codes select e_src_data[i]. No latches.
- Reset (async, rst_n=0): all tags 0, rw/mr/used 0, e_fwd_sel 0. As a result e_opnd=e_src_data and load_use_stall=0. A reset mid-operation discards all in-flight tags.

Optional Feature:
- Macro: FWD_WB_HOLD_EN.
- Defined:
  - Adds an X stage (W+1): tag dst_X/rw_X plus a DATA_W register capturing result_w when pipe_en=1 (reset 0).
  - Select priority becomes M > W > X. X is chosen when the W tag matches in D. SEL_X drives e_opnd from the X data register.
  - Intended for register files that write on the clock edge and read stale data.
- Undefined: no X stage and SEL_X is never generated.

Decomposition:
- Package fwd_pkg: SEL_* codes, select width 2, the bubble tag constant, and the struct/field layout of one tag.
- One natural sub-module: fwd_cmp. It compares one source against the E/M(/W) tags and returns the next select. It is instantiated NUM_SRC times by a generate loop.

Test Plan:
- ALU back-to-back: add r3 (E) then consumer reads r3 as src0 -> next cycle e_fwd_sel[0]=10 and e_opnd[0]=alu_out_m (0x00000055).
- Distance-2: producer r4, one independent instruction, then consumer src1=r4 -> e_fwd_sel[1]=01 and e_opnd[1]=result_w (0x12345678).
- Double hit: r5 written by both E and M tags -> SEL_M chosen. Destination r0 with rw=1 -> SEL_NORM.
- Load-use: lw r6 in E, D src0=r6 -> load_use_stall=1 for exactly 1 cycle, E bubble, then e_fwd_sel[0]=01 with the load data.
- pipe_en=0 for 3 cycles with flush_e=1 -> tags and e_fwd_sel unchanged. Flush on re-enable -> bubble, sel=00.
- Assert rst_n low mid-stream -> e_fwd_sel=0 and load_use_stall=0 immediately. With FWD_WB_HOLD_EN defined, a distance-3 hit gives sel=11.
